// File: rtl/systolic_output_deskewer_pkg.sv
// Shared constants, FSM state encoding and row type for the systolic array edge logic.
package systolic_output_deskewer_pkg;

  localparam int N      = 16;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  typedef logic [N-1:0][DATA_W-1:0] row_t;

  // True when every column agrees, i.e. the wavefront is not torn.
  function automatic logic all_equal(input logic [N-1:0] v);
    return (&v) | (~|v);
  endfunction

endpackage

// File: rtl/systolic_deskew_delay.sv
// Fixed-depth shift line carrying one column's data and valid; shifts every cycle, never stalls.
module systolic_deskew_delay
  import systolic_output_deskewer_pkg::*;
#(
  parameter int DEPTH = 1,
  parameter int W     = DATA_W + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] line_r [DEPTH];

  // Shift register stages, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        line_r[i] <= '0;
      end
    end else begin
      line_r[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        line_r[i] <= line_r[i-1];
      end
    end
  end

  assign q = line_r[DEPTH-1];

endmodule

// File: rtl/systolic_output_deskewer.sv
// Realigns the skewed bottom-edge wavefront into rows and writes them to the Unified Buffer.
// Optional macro SKEW_CHECK_EN adds a sticky torn-wavefront flag (skew_err).
module systolic_output_deskewer
  import systolic_output_deskewer_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N-1:0][DATA_W-1:0]   SA_data_in,
  input  logic [N-1:0]               SA_valid_in,
  input  logic                       start,
  input  logic [ADDR_W-1:0]          base_addr,
  input  logic [CNT_W-1:0]           row_cnt,
  output logic                       ubuf_wr_en,
  output logic [ADDR_W-1:0]          ubuf_wr_addr,
  output logic [N-1:0][DATA_W-1:0]   ubuf_data_out,
  output logic                       busy,
`ifdef SKEW_CHECK_EN
  output logic                       skew_err,
`endif
  output logic                       done
);

  logic [DATA_W-1:0] dly_data_s  [N];
  logic              dly_valid_s [N];
  row_t              data_q_r;
  logic [N-1:0]      valid_q_r;

  state_t            state_r, next_state_s;
  logic [ADDR_W-1:0] addr_q_r, last_addr_r, wr_addr_s;
  logic [CNT_W-1:0]  remaining_r;
  logic              accept_s, wr_en_s, busy_s, done_s;

  // Column j is early by N-1-j cycles, so it gets that many stages; column N-1 goes straight through.
  for (genvar j = 0; j < N - 1; j++) begin : g_col
    logic [DATA_W:0] q_s;
    systolic_deskew_delay #(.DEPTH(N - 1 - j), .W(DATA_W + 1)) u_dly (
      .clk (clk),
      .rst (rst),
      .d   ({SA_valid_in[j], SA_data_in[j]}),
      .q   (q_s)
    );
    assign dly_data_s[j]  = q_s[DATA_W-1:0];
    assign dly_valid_s[j] = q_s[DATA_W];
  end
  assign dly_data_s[N-1]  = SA_data_in[N-1];
  assign dly_valid_s[N-1] = SA_valid_in[N-1];

  // Common output register for the aligned row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q_r  <= '0;
      valid_q_r <= '0;
    end else begin
      for (int j = 0; j < N; j++) begin
        data_q_r[j]  <= dly_data_s[j];
        valid_q_r[j] <= dly_valid_s[j];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          next_state_s = (row_cnt == {CNT_W{1'b0}}) ? FIN : RUN;
        end else begin
          next_state_s = IDLE;
        end
      end
      RUN: begin
        if (wr_en_s && (remaining_r == CNT_W'(1))) begin
          next_state_s = FIN;
        end else begin
          next_state_s = RUN;
        end
      end
      FIN:     next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // FSM outputs; address port shows the live address only while writing.
  always_comb begin
    accept_s = (state_r == IDLE) && start;
    wr_en_s  = valid_q_r[0] && (state_r == RUN);
    busy_s   = (state_r == RUN) || (state_r == FIN);
    done_s   = (state_r == FIN);
    if (wr_en_s) begin
      wr_addr_s = addr_q_r;
    end else begin
      wr_addr_s = last_addr_r;
    end
  end

  // Transfer address and row counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q_r    <= '0;
      remaining_r <= '0;
      last_addr_r <= '0;
    end else begin
      if (accept_s) begin
        addr_q_r    <= base_addr;
        remaining_r <= row_cnt;
      end else if (wr_en_s) begin
        addr_q_r    <= addr_q_r + ADDR_W'(1);
        remaining_r <= remaining_r - CNT_W'(1);
      end
      if (wr_en_s) begin
        last_addr_r <= addr_q_r;
      end
    end
  end

`ifdef SKEW_CHECK_EN
  logic skew_err_r;

  // Sticky torn-wavefront flag; a fresh transfer clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skew_err_r <= 1'b0;
    end else begin
      skew_err_r <= ~all_equal(valid_q_r) | (skew_err_r & ~accept_s);
    end
  end

  assign skew_err = skew_err_r;
`else
  logic unused_valid_s;
  assign unused_valid_s = ^valid_q_r[N-1:1];
`endif

  assign ubuf_wr_en    = wr_en_s;
  assign ubuf_wr_addr  = wr_addr_s;
  assign ubuf_data_out = data_q_r;
  assign busy          = busy_s;
  assign done          = done_s;

endmodule
